// File: rtl/main_memory_pkg.sv
// Shared types and default constants for the main memory model.
// State encoding is fixed so waveforms line up with the cache controller's view.
package main_memory_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        READY = 2'd2
    } mem_state_t;

    localparam int MEM_LATENCY     = 4;
    localparam int MEM_BLOCK_WORDS = 4;

endpackage

// File: rtl/main_memory_if.sv
// Cache-controller <-> main-memory miss bus: level read request in, wide block out.
interface main_memory_if
    import main_memory_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 15,
    parameter int BLOCK_WORDS = MEM_BLOCK_WORDS
);
    logic                          read;
    logic [ADDR_W-1:0]             addr;
    logic                          mem_ready;
    logic [BLOCK_WORDS*DATA_W-1:0] block_data;
    logic                          busy;

    modport master (
        output read,
        output addr,
        input  mem_ready,
        input  block_data,
        input  busy
    );

    modport slave (
        input  read,
        input  addr,
        output mem_ready,
        output block_data,
        output busy
    );
endinterface

// File: rtl/mem_latency_counter.sv
// Loadable down-counter that times the FETCH phase; reloads to LATENCY-1 and
// holds at zero so the FSM can wait for the access to mature.
module mem_latency_counter
    import main_memory_pkg::*;
#(
    parameter int LATENCY = MEM_LATENCY
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic zero
);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= LOAD_VAL;
        end else if (en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);
endmodule

// File: rtl/main_memory.sv
// Block-organised read-only main memory: returns an aligned block LATENCY+1 cycles
// after a read request. Define MAIN_MEMORY_STATS_EN to add the access_count port.
module main_memory
    import main_memory_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 15,
    parameter int BLOCK_WORDS = MEM_BLOCK_WORDS,
    parameter int LATENCY     = MEM_LATENCY
) (
    input  logic         clk,
    input  logic         rst,
    main_memory_if.slave bus
`ifdef MAIN_MEMORY_STATS_EN
    ,
    output logic [15:0]  access_count
`endif
);
    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(BLOCK_WORDS - 1);

    mem_state_t                    r_state;
    mem_state_t                    w_state_next;
    logic [ADDR_W-1:0]             r_base;
    logic [BLOCK_WORDS*DATA_W-1:0] r_block_data;
    logic [BLOCK_WORDS*DATA_W-1:0] w_block_words;
    logic                          w_cnt_load;
    logic                          w_cnt_en;
    logic                          w_cnt_zero;
    logic                          w_capture;

    // The array holds mem[i] = i and has no write path, so each word is its own
    // zero-extended address.
    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return DATA_W'(a);
    endfunction

    generate
        for (genvar gi = 0; gi < BLOCK_WORDS; gi++) begin : g_block_word
            assign w_block_words[gi*DATA_W +: DATA_W] = mem_word(r_base + ADDR_W'(gi));
        end
    endgenerate

    mem_latency_counter #(
        .LATENCY (LATENCY)
    ) u_latency (
        .clk  (clk),
        .rst  (rst),
        .load (w_cnt_load),
        .en   (w_cnt_en),
        .zero (w_cnt_zero)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_load   = 1'b0;
        w_cnt_en     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.read) begin
                    w_state_next = FETCH;
                    w_cnt_load   = 1'b1;
                end
            end
            FETCH: begin
                // Dropping read mid-fetch abandons the access without a pulse.
                if (!bus.read) begin
                    w_state_next = IDLE;
                end else if (w_cnt_zero) begin
                    w_state_next = READY;
                    w_capture    = 1'b1;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            READY:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_base       <= '0;
            r_block_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && bus.read) begin
                r_base <= bus.addr & ~OFFSET_MASK;
            end
            if (w_capture) begin
                r_block_data <= w_block_words;
            end
        end
    end

`ifdef MAIN_MEMORY_STATS_EN
    logic [15:0] r_access_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_access_count <= '0;
        end else if (w_capture) begin
            r_access_count <= r_access_count + 16'd1;
        end
    end

    assign access_count = r_access_count;
`endif

    assign bus.mem_ready  = (r_state == READY);
    assign bus.busy       = (r_state != IDLE);
    assign bus.block_data = r_block_data;
endmodule

// File: doc/main_memory.md
# main_memory

Block-organised main memory model that sits directly downstream of the direct-mapped data cache controller and serves its miss traffic. It accepts a level read request and a word address, waits a fixed access latency, then returns a full cache block on a wide bus with a one-cycle `mem_ready` pulse. This timing matches the controller's WAITING→MISING transition. It is a synthesizable-style behavioural model used in the cache testbench and top-level integration.

## Interface
- `DATA_W`, 32: bits per word.
- `ADDR_W`, 15: word-address width; array depth is 2^ADDR_W words.
- `BLOCK_WORDS`, 4: words per block; must be a power of two, at least 2.
- `LATENCY`, 4: FETCH cycles per access; must be at least 1.
- `clk`  in  1  sole clock; rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `read`  in  1  level request from the cache controller, held while the controller waits.
- `addr`  in  ADDR_W  word address of the missing word.
- `mem_ready`  out  1  one-cycle pulse; `block_data` is valid in that cycle.
- `block_data`  out  BLOCK_WORDS*DATA_W  block contents; word 0 is in the LSBs.
- `busy`  out  1  high in FETCH and READY.
- `access_count`  out  16  number of completed accesses; present only with the stats macro.

## Operation
- The FSM has three states: IDLE, FETCH, READY.
- IDLE → FETCH when `read`=1.
  - On this transition, latch `base` = `addr` with its low log2(BLOCK_WORDS) bits cleared.
  - Load `cnt` = LATENCY-1.
- FETCH:
  - If `read`=0, abort to IDLE. No pulse is issued, `block_data` is unchanged, and the count is not incremented.
  - Else if `cnt`=0, go to READY and register `block_data[i]` = `mem[base+i]` for i = 0..BLOCK_WORDS-1.
  - Otherwise decrement `cnt`.
- READY → IDLE unconditionally. A `read` still high in READY is ignored; a new access needs `read` high in a later IDLE cycle.
- `mem_ready` is decoded from state READY only. `busy` is (state != IDLE).
- Block base arithmetic is unsigned and modulo 2^ADDR_W. No block crosses the top of the array, because bases are aligned.
- Array contents:
  - Initialised at time zero to `mem[i]` = i, zero-extended to DATA_W.
  - Not affected by `rst`.
  - The block has no write path. Cache writes are write-through and are handled elsewhere.
- Reset values:
  - FSM = IDLE, `cnt` = 0, `mem_ready` = 0, `busy` = 0.
  - `block_data` = 0, `access_count` = 0.
- Reset mid-FETCH or in READY returns to IDLE on the next edge with no pulse. `rst` has priority over all transitions.

## Timing
- Let `read` first be sampled high in IDLE at cycle 0.
  - FETCH occupies cycles 1..LATENCY.
  - `mem_ready` is high in cycle LATENCY+1 only.
  - `busy` is high in cycles 1..LATENCY+1.
- Latency: request to data is LATENCY+1 cycles. With the default, `mem_ready` asserts in cycle 5.
- `block_data` changes only on the FETCH→READY edge and holds until the next completed access.
- `addr` is sampled only at IDLE→FETCH. Changes to `addr` during FETCH are ignored.
- Back-to-back accesses: the earliest next request is sampled in the IDLE cycle after READY. Minimum period is LATENCY+2 cycles.

## Configuration
- `MAIN_MEMORY_STATS_EN` defined:
  - The `access_count` port and a 16-bit counter exist.
  - The counter increments on every FETCH→READY transition and wraps 0xFFFF→0x0000.
  - It resets to 0. Aborted accesses do not count.
- `MAIN_MEMORY_STATS_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `main_memory_pkg` holds:
  - the state encoding `mem_state_t` (IDLE=0, FETCH=1, READY=2);
  - the default constants `MEM_LATENCY`=4 and `MEM_BLOCK_WORDS`=4.
- Sub-module `mem_latency_counter`:
  - loadable down-counter of width $clog2(LATENCY) (minimum 1);
  - inputs `load`/`en`, output `zero`;
  - the FSM instantiates it once.
- The array and block assembly stay in the top module.

## Test plan
- Reset, then `read`=1, `addr`=0x0006, held. Expect:
  - `mem_ready` high in cycle 5 only, `busy` high in cycles 1–5;
  - `block_data` = {0x7,0x6,0x5,0x4} (word 3 in the MSBs).
- `addr`=0x7FFD at request, changed to 0x0000 in cycle 2. Expect `block_data` = {0x7FFF,0x7FFE,0x7FFD,0x7FFC}; the late `addr` is ignored.
- `read` dropped in cycle 3. Expect:
  - IDLE in cycle 4, no `mem_ready` pulse;
  - `block_data` keeps its previous value; `access_count` unchanged.
- `read` held continuously across two accesses. Expect `mem_ready` pulses in cycles 5 and 11, and `access_count`=2 with stats enabled.
- `rst` asserted in cycle 4 of an access. Expect:
  - no `mem_ready` pulse;
  - all outputs at their reset values next cycle; a fresh request afterwards completes normally.
- Closed loop with the cache controller on a miss at address 0x0010. Expect:
  - controller `read` high for 5 cycles;
  - MISING coincides with `mem_ready`;
  - a subsequent hit to 0x0011 completes without memory activity.
